// File: rtl/wb_stage_buffer_if.sv
// Handshake and writeback bundle between the memory stage, the writeback
// buffer and the register file.
interface wb_stage_buffer_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_wb_en;
    logic                  in_mem_r_en;
    logic [DATA_W-1:0]     in_alu_result;
    logic [DATA_W-1:0]     in_mem_data;
    logic [REG_ADDR_W-1:0] in_dest;
    logic                  wb_en;
    logic [DATA_W-1:0]     wb_value;
    logic [REG_ADDR_W-1:0] write_src_reg;
    logic                  fwd_valid;
    logic [REG_ADDR_W-1:0] fwd_dest;

    // Memory-stage / register-file side
    modport master (
        output in_valid, in_wb_en, in_mem_r_en, in_alu_result, in_mem_data, in_dest,
        input  in_ready, wb_en, wb_value, write_src_reg, fwd_valid, fwd_dest
    );

    // Writeback buffer side
    modport slave (
        input  in_valid, in_wb_en, in_mem_r_en, in_alu_result, in_mem_data, in_dest,
        output in_ready, wb_en, wb_value, write_src_reg, fwd_valid, fwd_dest
    );
endinterface

// File: rtl/wb_stage_buffer.sv
// Two-entry writeback buffer: captures completed instructions from the memory
// stage and presents one register-file write per cycle.
module wb_stage_buffer #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4,
    parameter int CNT_W      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 wb_hold,
    output logic [CNT_W-1:0]     retired_count,
    wb_stage_buffer_if.slave     bus
);
    localparam logic [REG_ADDR_W-1:0] PC_REG = {REG_ADDR_W{1'b1}};

    logic                  r_entWbEn  [2];
    logic [REG_ADDR_W-1:0] r_entDest  [2];
    logic [DATA_W-1:0]     r_entValue [2];
    logic                  r_rdPtr;
    logic                  r_wrPtr;
    logic [1:0]            r_count;
    logic [CNT_W-1:0]      r_retired;

    logic                  w_notEmpty;
    logic                  w_ready;
    logic                  w_accept;
    logic                  w_drain;
    logic                  w_headWbEn;
    logic [REG_ADDR_W-1:0] w_headDest;
    logic [DATA_W-1:0]     w_headValue;
    logic [DATA_W-1:0]     w_inValue;

    assign w_notEmpty  = (r_count != 2'd0);
    assign w_ready     = (r_count != 2'd2);
    assign w_accept    = bus.in_valid & w_ready;
    assign w_drain     = w_notEmpty & ~wb_hold;
    assign w_inValue   = bus.in_mem_r_en ? bus.in_mem_data : bus.in_alu_result;
    assign w_headWbEn  = r_entWbEn[r_rdPtr];
    assign w_headDest  = r_entDest[r_rdPtr];
    assign w_headValue = r_entValue[r_rdPtr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                r_entWbEn[i]  <= 1'b0;
                r_entDest[i]  <= '0;
                r_entValue[i] <= '0;
            end
            r_rdPtr   <= 1'b0;
            r_wrPtr   <= 1'b0;
            r_count   <= 2'd0;
            r_retired <= '0;
        end else if (flush) begin
            // Retired count deliberately untouched: flushed entries never retired
            r_rdPtr <= 1'b0;
            r_wrPtr <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_accept) begin
                r_entWbEn[r_wrPtr]  <= bus.in_wb_en;
                r_entDest[r_wrPtr]  <= bus.in_dest;
                r_entValue[r_wrPtr] <= w_inValue;
                r_wrPtr             <= ~r_wrPtr;
            end
            if (w_drain) begin
                r_rdPtr   <= ~r_rdPtr;
                r_retired <= r_retired + CNT_W'(1);
            end
            r_count <= r_count + {1'b0, w_accept} - {1'b0, w_drain};
        end
    end

    // The PC has no register-file slot, so its writes are dropped but still drain
    assign bus.wb_en         = w_notEmpty & w_headWbEn & ~wb_hold & (w_headDest != PC_REG);
    assign bus.wb_value      = w_headValue;
    assign bus.write_src_reg = w_headDest;
    assign bus.fwd_valid     = w_notEmpty & w_headWbEn;
    assign bus.fwd_dest      = w_headDest;
    assign bus.in_ready      = w_ready;
    assign retired_count     = r_retired;
endmodule

// File: tb/tb_wb_stage_buffer.sv
// Directed testbench for wb_stage_buffer: hand-computed expectations checked
// one cycle at a time, one side of the rising edge away.
module tb_wb_stage_buffer;
    logic        clk;
    logic        rst;
    logic        flush;
    logic        wb_hold;
    logic [31:0] retired_count;
    int          vectors;
    int          miscompares;

    wb_stage_buffer_if #(.DATA_W(32), .REG_ADDR_W(4)) bus ();

    wb_stage_buffer #(.DATA_W(32), .REG_ADDR_W(4), .CNT_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .wb_hold       (wb_hold),
        .retired_count (retired_count),
        .bus           (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic wbEn, input logic memREn,
                                 input logic [31:0] alu, input logic [31:0] mem,
                                 input logic [3:0] dest);
        bus.in_valid      = valid;
        bus.in_wb_en      = wbEn;
        bus.in_mem_r_en   = memREn;
        bus.in_alu_result = alu;
        bus.in_mem_data   = mem;
        bus.in_dest       = dest;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        flush       = 1'b0;
        wb_hold     = 1'b0;
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 4'd0);
        tick();
        tick();
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("rst_wb_en", 32'(bus.wb_en), 32'd0);
        checkOutput("rst_retired", retired_count, 32'd0);
        checkOutput("rst_fwd_valid", 32'(bus.fwd_valid), 32'd0);
        checkOutput("rst_wb_value", bus.wb_value, 32'd0);
        checkOutput("rst_src_reg", 32'(bus.write_src_reg), 32'd0);
        rst = 1'b1;
        tick();

        // Single ALU op
        applyStimulus(1, 1, 0, 32'h12, 32'h0, 4'd3);
        tick();
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 4'd0);
        checkOutput("alu_wb_en", 32'(bus.wb_en), 32'd1);
        checkOutput("alu_value", bus.wb_value, 32'h12);
        checkOutput("alu_src_reg", 32'(bus.write_src_reg), 32'd3);
        checkOutput("alu_fwd_dest", 32'(bus.fwd_dest), 32'd3);
        tick();
        checkOutput("alu_drained_wb_en", 32'(bus.wb_en), 32'd0);
        checkOutput("alu_retired", retired_count, 32'd1);

        // Load select
        applyStimulus(1, 1, 1, 32'h40, 32'hDEAD_BEEF, 4'd7);
        tick();
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 4'd0);
        checkOutput("load_wb_en", 32'(bus.wb_en), 32'd1);
        checkOutput("load_value", bus.wb_value, 32'hDEAD_BEEF);
        checkOutput("load_src_reg", 32'(bus.write_src_reg), 32'd7);
        tick();
        checkOutput("load_retired", retired_count, 32'd2);

        // Back-to-back with hold
        wb_hold = 1'b1;
        applyStimulus(1, 1, 0, 32'hA, 32'h0, 4'd1);
        tick();
        applyStimulus(1, 1, 0, 32'hB, 32'h0, 4'd2);
        tick();
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 4'd0);
        checkOutput("hold_in_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("hold_wb_en", 32'(bus.wb_en), 32'd0);
        checkOutput("hold_fwd_valid", 32'(bus.fwd_valid), 32'd1);
        checkOutput("hold_fwd_dest", 32'(bus.fwd_dest), 32'd1);
        tick();
        checkOutput("hold_stay_ready", 32'(bus.in_ready), 32'd0);
        checkOutput("hold_stay_retired", retired_count, 32'd2);
        wb_hold = 1'b0;
        #1;
        checkOutput("rel1_wb_en", 32'(bus.wb_en), 32'd1);
        checkOutput("rel1_src_reg", 32'(bus.write_src_reg), 32'd1);
        checkOutput("rel1_value", bus.wb_value, 32'hA);
        tick();
        checkOutput("rel2_wb_en", 32'(bus.wb_en), 32'd1);
        checkOutput("rel2_src_reg", 32'(bus.write_src_reg), 32'd2);
        checkOutput("rel2_value", bus.wb_value, 32'hB);
        checkOutput("rel2_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        checkOutput("rel_empty_wb_en", 32'(bus.wb_en), 32'd0);
        checkOutput("rel_retired", retired_count, 32'd4);

        // Dest 15 then a no-write entry; the second enters while the first drains
        applyStimulus(1, 1, 0, 32'h55, 32'h0, 4'd15);
        tick();
        applyStimulus(1, 0, 0, 32'h66, 32'h0, 4'd5);
        #1;
        checkOutput("pc_wb_en", 32'(bus.wb_en), 32'd0);
        checkOutput("pc_fwd_valid", 32'(bus.fwd_valid), 32'd1);
        checkOutput("pc_fwd_dest", 32'(bus.fwd_dest), 32'd15);
        tick();
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 4'd0);
        checkOutput("nowr_wb_en", 32'(bus.wb_en), 32'd0);
        checkOutput("nowr_fwd_valid", 32'(bus.fwd_valid), 32'd0);
        checkOutput("nowr_src_reg", 32'(bus.write_src_reg), 32'd5);
        checkOutput("nowr_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        checkOutput("nowr_retired", retired_count, 32'd6);
        checkOutput("nowr_empty_wb_en", 32'(bus.wb_en), 32'd0);

        // Flush: head still written in the flush cycle, nothing counted
        wb_hold = 1'b1;
        applyStimulus(1, 1, 0, 32'h44, 32'h0, 4'd4);
        tick();
        applyStimulus(1, 1, 0, 32'h66, 32'h0, 4'd6);
        tick();
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 4'd0);
        checkOutput("fl_full_ready", 32'(bus.in_ready), 32'd0);
        wb_hold = 1'b0;
        flush   = 1'b1;
        #1;
        checkOutput("fl_cycle_wb_en", 32'(bus.wb_en), 32'd1);
        checkOutput("fl_cycle_src_reg", 32'(bus.write_src_reg), 32'd4);
        tick();
        flush = 1'b0;
        checkOutput("fl_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("fl_wb_en", 32'(bus.wb_en), 32'd0);
        checkOutput("fl_fwd_valid", 32'(bus.fwd_valid), 32'd0);
        checkOutput("fl_retired", retired_count, 32'd6);
        applyStimulus(1, 1, 0, 32'h88, 32'h0, 4'd8);
        tick();
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 4'd0);
        checkOutput("post_fl_value", bus.wb_value, 32'h88);
        checkOutput("post_fl_src_reg", 32'(bus.write_src_reg), 32'd8);
        tick();
        checkOutput("post_fl_retired", retired_count, 32'd7);

        // Async reset between edges with a full buffer
        wb_hold = 1'b1;
        applyStimulus(1, 1, 0, 32'h99, 32'h0, 4'd9);
        tick();
        applyStimulus(1, 1, 0, 32'hAA, 32'h0, 4'd10);
        tick();
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 4'd0);
        wb_hold = 1'b0;
        #1;
        checkOutput("pre_rst_wb_en", 32'(bus.wb_en), 32'd1);
        checkOutput("pre_rst_ready", 32'(bus.in_ready), 32'd0);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("arst_wb_en", 32'(bus.wb_en), 32'd0);
        checkOutput("arst_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("arst_fwd_valid", 32'(bus.fwd_valid), 32'd0);
        checkOutput("arst_retired", retired_count, 32'd0);
        tick();
        rst = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/wb_stage_buffer.md
Name: wb_stage_buffer

Overview:
- Writeback stage between the memory stage (cache-backed, variable latency) and the register file.
- Accepts completed instructions over a valid/ready handshake and selects the writeback value (ALU result or load data).
- Buffers up to 2 results and presents one per cycle as `wb_en` / `wb_value` / `write_src_reg`. The register file commits these on the falling edge of the same cycle.
- Also exports the head destination for forwarding/hazard logic, and a retired-instruction counter.

Parameters:
- DATA_W, 32, width of register values
- REG_ADDR_W, 4, register index width
- CNT_W, 32, retired counter width

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  memory stage presents a completed instruction
- in_ready  output  1  buffer can accept this cycle
- in_wb_en  input  1  instruction writes a register
- in_mem_r_en  input  1  instruction is a load; select in_mem_data
- in_alu_result  input  DATA_W  ALU result
- in_mem_data  input  DATA_W  load data from cache
- in_dest  input  REG_ADDR_W  destination register
- flush  input  1  synchronous discard of all buffered entries
- wb_hold  input  1  freeze draining (debug/freeze)
- wb_en  output  1  register file write enable
- wb_value  output  DATA_W  register file write data
- write_src_reg  output  REG_ADDR_W  register file write address
- fwd_valid  output  1  head entry valid and writes a register
- fwd_dest  output  REG_ADDR_W  head destination for hazard/forwarding
- retired_count  output  CNT_W  instructions drained since reset

Behaviour:
- Storage is a 2-entry circular FIFO with 1-bit rd_ptr and wr_ptr and a 2-bit count.
  - Each entry holds wb_en, dest and value.
  - value = in_mem_r_en ? in_mem_data : in_alu_result, captured at enqueue. The select flag is not stored.
- Reset (rst low, asynchronous):
  - count = 0, pointers = 0, retired_count = 0.
  - Outputs: in_ready = 1, wb_en = 0, fwd_valid = 0, wb_value = 0, write_src_reg = 0, fwd_dest = 0.
  - Entry contents are cleared to 0.
- in_ready = (count != 2). It depends only on registered state, never combinationally on in_valid.
- accept = in_valid & in_ready. On the rising edge, the entry is written at wr_ptr and wr_ptr toggles.
- drain = (count != 0) & ~wb_hold. On the rising edge, rd_ptr toggles and retired_count increments, wrapping from 2^CNT_W-1 to 0.
  - Entries with wb_en=0 still occupy a slot, drain normally and count as retired.
- Head outputs are combinational from the registered head entry:
  - wb_en = (count != 0) & head.wb_en & ~wb_hold & (head.dest != 4'hF).
  - wb_value = head.value, write_src_reg = head.dest.
  - fwd_valid = (count != 0) & head.wb_en; fwd_dest = head.dest. These are not gated by wb_hold.
- Destination 15 (PC) has no register-file entry. wb_en is suppressed for dest 15, but the entry still drains and is counted.
- Latency:
  - An instruction accepted at rising edge N appears at the head in cycle N (if the buffer was empty).
  - The register file writes it at the falling edge of cycle N, and it drains at rising edge N+1.
  - Steady-state throughput is 1 per cycle.
- Count update:
  - count += accept − drain.
  - Accept and drain in the same cycle with count==1 leaves count 1 and presents the new entry next cycle.
  - With count==2 no accept is possible; a drain makes in_ready=1 the following cycle.
  - count==0 with accept and no drain (nothing to drain) gives count 1.
- flush has priority over accept and drain:
  - count = 0, rd_ptr = wr_ptr = 0, and retired_count is unchanged.
  - wb_en remains combinationally active during the flush cycle if the head qualifies, so the current head is still written at that falling edge.
- wb_hold with count==2 keeps in_ready=0 indefinitely; the contents hold stable.
- Reset asserted mid-operation discards all entries immediately, with no partial writeback.

Test Plan:
- Reset then idle: rst low 2 cycles → in_ready=1, wb_en=0, retired_count=0, fwd_valid=0.
- Single ALU op: in_valid=1, in_wb_en=1, in_mem_r_en=0, alu=32'h12, dest=3 for one cycle → next cycle wb_en=1, wb_value=32'h12, write_src_reg=3; one cycle later wb_en=0, retired_count=1.
- Load select: in_mem_r_en=1, mem_data=32'hDEAD_BEEF, alu=32'h40, dest=7 → wb_value=32'hDEAD_BEEF, write_src_reg=7.
- Back-to-back with hold:
  - wb_hold=1, push dest1=32'hA and dest2=32'hB → count 2, in_ready=0, wb_en=0, fwd_dest=1.
  - Release wb_hold → wb_en for dest 1 then dest 2 in consecutive cycles, in_ready=1 after the first drain, retired_count=2.
- Dest 15 and no-write: push dest=15 with in_wb_en=1, then dest=5 with in_wb_en=0 → wb_en never asserts, retired_count=2.
- Flush and async reset:
  - Fill 2 entries with wb_hold=1, pulse flush → count 0, in_ready=1, retired_count unchanged.
  - Refill and drop rst between clock edges → wb_en=0 and in_ready=1 immediately, before the next edge.
